// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory
// and queues returned words with their PCs for decode; redirects squash the old path.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [CW:0]   occupancy;
  logic [31:0]   redirect_base;
  logic          pop;
  logic          push;
  logic          req_fire;
  logic          drop;

  assign instr_valid   = (count != '0) & ~redirect_valid;
  assign pop           = instr_valid & instr_ready;

  // Every in-flight request reserves a queue slot, so a response always has room.
  assign occupancy      = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
  assign imem_req_valid = ~reset & ~redirect_valid & (occupancy < DEPTH_OCC);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign drop          = (kill != '0);
  assign push          = imem_rsp_valid & ~drop & ~redirect_valid;
  assign redirect_base = redirect_pc & ~32'h3;

  assign instr    = data_q[head];
  assign instr_pc = pc_q[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (redirect_valid) begin
      // Whatever is still in flight belongs to the old path and must be discarded.
      fetch_pc    <= redirect_base;
      rsp_pc      <= redirect_base;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      kill        <= outstanding - CW'(imem_rsp_valid);
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && drop) kill <= kill - CW'(1);
      if (push) begin
        tail   <= tail + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]   <= rsp_pc;
      data_q[tail] <= imem_rsp_data;
    end
  end

endmodule
